// File: rtl/mat_switch.sv
// Inter-core mailbox switch: one single-entry mailbox per (source, destination) core pair.
// Each core has independent send and receive handshake paths, each a registered IDLE/ACK FSM.
module mat_switch #(
    parameter int SWITCH_WIDTH          = 16,
    parameter int SWITCH_CORE_SIZE      = 4,
    parameter int SWITCH_CORE_ADDR_SIZE = $clog2(SWITCH_CORE_SIZE)
) (
    input  logic                                                      clock,
    input  logic                                                      reset,
    input  logic [SWITCH_CORE_SIZE-1:0]                               send_ready,
    input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_ADDR_SIZE-1:0]    send_core_idx,
    input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_WIDTH-1:0][31:0]       send_data,
    output logic [SWITCH_CORE_SIZE-1:0]                               send_ok,
    input  logic [SWITCH_CORE_SIZE-1:0]                               recv_request,
    input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_ADDR_SIZE-1:0]    recv_core_idx,
    output logic [SWITCH_CORE_SIZE-1:0]                               recv_ready,
    output logic [SWITCH_CORE_SIZE-1:0][SWITCH_WIDTH-1:0][31:0]       recv_data,
    output logic [SWITCH_CORE_SIZE*SWITCH_CORE_SIZE-1:0]              slot_full
);

    localparam int N = SWITCH_CORE_SIZE;
    localparam int A = SWITCH_CORE_ADDR_SIZE;
    localparam int W = SWITCH_WIDTH;

    // Words travel as raw single-precision bit patterns; the switch never interprets them.
    typedef logic [W-1:0][31:0] vec_t;

    // Handshake rule: a request is held until its pulse; the pulse (ACK state) lasts one
    // cycle and any request still present during it is ignored.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } hs_state_e;

    hs_state_e send_st_q [N];
    hs_state_e send_st_d [N];
    hs_state_e recv_st_q [N];
    hs_state_e recv_st_d [N];

    logic [N-1:0][N-1:0]          mb_valid_q;
    logic [N-1:0][N-1:0]          mb_valid_d;
    logic [N-1:0][N-1:0][W*32-1:0] mb_data_q;
    logic [N-1:0][N-1:0][W*32-1:0] mb_data_d;
    vec_t [N-1:0]                  recv_data_q;
    vec_t [N-1:0]                  recv_data_d;

    // A fill needs an empty slot and a drain needs a full one at cycle start, so the
    // two loops below never touch the same slot in the same cycle.
    always_comb begin
        mb_valid_d  = mb_valid_q;
        mb_data_d   = mb_data_q;
        recv_data_d = recv_data_q;
        for (int c = 0; c < N; c++) begin
            send_st_d[c] = ST_IDLE;
            recv_st_d[c] = ST_IDLE;

            if (send_st_q[c] == ST_IDLE && send_ready[c] &&
                !mb_valid_q[c][send_core_idx[c]]) begin
                mb_valid_d[c][send_core_idx[c]] = 1'b1;
                mb_data_d[c][send_core_idx[c]]  = send_data[c];
                send_st_d[c]                    = ST_ACK;
            end

            if (recv_st_q[c] == ST_IDLE && recv_request[c] &&
                mb_valid_q[recv_core_idx[c]][c]) begin
                mb_valid_d[recv_core_idx[c]][c] = 1'b0;
                recv_data_d[c]                  = mb_data_q[recv_core_idx[c]][c];
                recv_st_d[c]                    = ST_ACK;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mb_valid_q  <= '0;
            recv_data_q <= '0;
            for (int c = 0; c < N; c++) begin
                send_st_q[c] <= ST_IDLE;
                recv_st_q[c] <= ST_IDLE;
            end
        end else begin
            mb_valid_q  <= mb_valid_d;
            recv_data_q <= recv_data_d;
            for (int c = 0; c < N; c++) begin
                send_st_q[c] <= send_st_d[c];
                recv_st_q[c] <= recv_st_d[c];
            end
        end
    end

    // Payload storage is qualified by mb_valid_q, so it needs no reset.
    always_ff @(posedge clock) begin
        mb_data_q <= mb_data_d;
    end

    for (genvar g = 0; g < N; g++) begin : g_out
        assign send_ok[g]    = (send_st_q[g] == ST_ACK);
        assign recv_ready[g] = (recv_st_q[g] == ST_ACK);

        a_send_ok_single : assert property (@(posedge clock) disable iff (reset)
            send_ok[g] |=> !send_ok[g]);
        a_recv_ready_single : assert property (@(posedge clock) disable iff (reset)
            recv_ready[g] |=> !recv_ready[g]);
    end

    assign recv_data = recv_data_q;
    // Packed [src][dst] flattens to bit src*N+dst.
    assign slot_full = mb_valid_q;

endmodule

// File: tb/tb_mat_switch.sv
// Directed bench for mat_switch: payloads are pushed to an expected queue when sent
// and popped/compared when the destination core sees recv_ready.
module tb_mat_switch;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int A  = 2;
    localparam int DW = W * 32;

    logic                        clock = 1'b0;
    logic                        reset;
    logic [N-1:0]                send_ready;
    logic [N-1:0][A-1:0]         send_core_idx;
    logic [N-1:0][W-1:0][31:0]   send_data;
    logic [N-1:0]                send_ok;
    logic [N-1:0]                recv_request;
    logic [N-1:0][A-1:0]         recv_core_idx;
    logic [N-1:0]                recv_ready;
    logic [N-1:0][W-1:0][31:0]   recv_data;
    logic [N*N-1:0]              slot_full;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];

    mat_switch #(
        .SWITCH_WIDTH     (W),
        .SWITCH_CORE_SIZE (N)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .send_ready    (send_ready),
        .send_core_idx (send_core_idx),
        .send_data     (send_data),
        .send_ok       (send_ok),
        .recv_request  (recv_request),
        .recv_core_idx (recv_core_idx),
        .recv_ready    (recv_ready),
        .recv_data     (recv_data),
        .slot_full     (slot_full)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    // IEEE-754 single pattern of a small positive integer.
    function automatic logic [31:0] fp_of_int(int k);
        int e;
        e = 0;
        while ((k >> (e + 1)) != 0) e++;
        return (32'(127 + e) << 23) | ((32'(k) - (32'd1 << e)) << (23 - e));
    endfunction

    function automatic logic [DW-1:0] fill_vec(int k);
        logic [DW-1:0] v;
        for (int i = 0; i < W; i++) v[i*32 +: 32] = fp_of_int(k);
        return v;
    endfunction

    function automatic logic [DW-1:0] ramp_vec(int base);
        logic [DW-1:0] v;
        for (int i = 0; i < W; i++) v[i*32 +: 32] = fp_of_int(base + i);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_send(input int c, input int dst, input logic [DW-1:0] v, input bit push);
        send_ready[c]    = 1'b1;
        send_core_idx[c] = A'(dst);
        send_data[c]     = v;
        if (push) exp_q.push_back(v);
    endtask

    task automatic wait_send_ok(input int c, input string tag);
        for (int i = 0; i < 40 && !send_ok[c]; i++) tick();
        chk(tag, DW'(send_ok[c]), DW'(1));
        send_ready[c] = 1'b0;
    endtask

    task automatic start_recv(input int c, input int src);
        recv_request[c]  = 1'b1;
        recv_core_idx[c] = A'(src);
    endtask

    task automatic wait_recv(input int c, input string tag);
        logic [DW-1:0] e;
        for (int i = 0; i < 40 && !recv_ready[c]; i++) tick();
        chk({tag, "_rdy"}, DW'(recv_ready[c]), DW'(1));
        recv_request[c] = 1'b0;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s_sb observed=empty_queue expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_data"}, recv_data[c], e);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int order [3];
        order = '{2, 0, 1};

        reset         = 1'b1;
        send_ready    = '0;
        send_core_idx = '0;
        send_data     = '0;
        recv_request  = '0;
        recv_core_idx = '0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (5) tick();

        chk("reset_send_ok",    DW'(send_ok),    '0);
        chk("reset_recv_ready", DW'(recv_ready), '0);
        chk("reset_slot_full",  DW'(slot_full),  '0);
        chk("reset_recv_data",  recv_data[0] | recv_data[1] | recv_data[2] | recv_data[3], '0);

        // Core0 -> core2 ramp 1.0..16.0
        start_send(0, 2, ramp_vec(1), 1'b1);
        tick();
        chk("t2_send_ok", DW'(send_ok), DW'(4'b0001));
        send_ready[0] = 1'b0;
        chk("t2_slot_set", DW'(slot_full), DW'(16'h0004));
        tick();
        chk("t2_send_ok_once", DW'(send_ok), '0);
        start_recv(2, 0);
        tick();
        chk("t2_recv_ready", DW'(recv_ready), DW'(4'b0100));
        wait_recv(2, "t2");
        chk("t2_slot_clr", DW'(slot_full), '0);
        tick();
        chk("t2_recv_once", DW'(recv_ready), '0);

        // Core1 -> core3 twice; second stalls on the full slot
        start_send(1, 3, fill_vec(5), 1'b1);
        wait_send_ok(1, "t3_first");
        start_send(1, 3, fill_vec(7), 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t3_stall", DW'(send_ok[1]), '0);
            chk("t3_slot", DW'(slot_full), DW'(16'h0080));
        end
        start_recv(3, 1);
        wait_recv(3, "t3_a");
        wait_send_ok(1, "t3_second");
        tick();
        start_recv(3, 1);
        wait_recv(3, "t3_b");
        tick();

        // Cores 0,1,2 -> core3 simultaneously, drained in order 2,0,1
        start_send(0, 3, fill_vec(10), 1'b0);
        start_send(1, 3, fill_vec(11), 1'b0);
        start_send(2, 3, fill_vec(12), 1'b0);
        exp_q.push_back(fill_vec(12));
        exp_q.push_back(fill_vec(10));
        exp_q.push_back(fill_vec(11));
        tick();
        chk("t4_send_ok", DW'(send_ok), DW'(4'b0111));
        send_ready = '0;
        chk("t4_slots", DW'(slot_full), DW'(16'h0888));
        for (int k = 0; k < 3; k++) begin
            tick();
            start_recv(3, order[k]);
            wait_recv(3, "t4");
        end
        tick();

        // Core2 waits on empty mailbox from core1, then core1 sends
        start_recv(2, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t5_idle", DW'(recv_ready[2]), '0);
        end
        start_send(1, 2, ramp_vec(20), 1'b1);
        wait_send_ok(1, "t5_send");
        tick();
        chk("t5_latency", DW'(recv_ready[2]), DW'(1));
        wait_recv(2, "t5");
        tick();

        // Self-send on core0, received the next cycle
        start_send(0, 0, ramp_vec(100), 1'b1);
        wait_send_ok(0, "t6_send");
        start_recv(0, 0);
        wait_recv(0, "t6");
        tick();

        // Reset during the send_ok cycle discards the message
        start_send(1, 2, fill_vec(9), 1'b0);
        tick();
        chk("t7_accept", DW'(send_ok), DW'(4'b0010));
        reset      = 1'b1;
        send_ready = '0;
        tick();
        reset = 1'b0;
        chk("t7_send_ok_rst", DW'(send_ok), '0);
        chk("t7_slot_rst", DW'(slot_full), '0);
        tick();
        chk("t7_send_ok_after", DW'(send_ok), '0);
        chk("t7_recv_ready_after", DW'(recv_ready), '0);
        chk("t7_slot_after", DW'(slot_full), '0);
        chk("t7_recv_data_rst", recv_data[0] | recv_data[1] | recv_data[2] | recv_data[3], '0);
        chk("sb_drained", DW'(exp_q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mat_switch.md
Name: mat_switch

Overview:
- Inter-core message switch; it is the responder end of the MatCore switch send/recv interface.
- Connects SWITCH_CORE_SIZE cores and holds one single-entry mailbox per (source, destination) pair.
- A core's send request deposits one vector of SWITCH_WIDTH shortreal words into mailbox[src][dst].
- A core's receive request for a given source drains mailbox[src][self] and returns the vector.

Parameters:
- SWITCH_WIDTH, 16, shortreal words per message.
- SWITCH_CORE_SIZE, 4, number of attached cores; must be a power of 2, >= 2.
- SWITCH_CORE_ADDR_SIZE, $clog2(SWITCH_CORE_SIZE), core index width (derived).

Ports (per-core ports are arrays indexed by core c):
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- send_ready  input  [SWITCH_CORE_SIZE]  core c requests a send.
- send_core_idx  input  [SWITCH_CORE_SIZE] x SWITCH_CORE_ADDR_SIZE  destination core of c's send.
- send_data  input  [SWITCH_CORE_SIZE] x SWITCH_WIDTH shortreal  payload of c's send.
- send_ok  output  [SWITCH_CORE_SIZE]  one-cycle acceptance pulse to core c.
- recv_request  input  [SWITCH_CORE_SIZE]  core c requests a receive.
- recv_core_idx  input  [SWITCH_CORE_SIZE] x SWITCH_CORE_ADDR_SIZE  source core c wants data from.
- recv_ready  output  [SWITCH_CORE_SIZE]  one-cycle data-valid pulse to core c.
- recv_data  output  [SWITCH_CORE_SIZE] x SWITCH_WIDTH shortreal  payload to c; valid only while recv_ready=1.
- slot_full  output  SWITCH_CORE_SIZE*SWITCH_CORE_SIZE  mailbox occupancy, bit src*SWITCH_CORE_SIZE+dst (status/debug).

Behaviour:
- State:
  - Mailbox array mb_valid[src][dst] and mb_data[src][dst].
  - Registered send_ok, recv_ready and recv_data.
  - Each per-core path is a 2-state FSM: IDLE and ACK. ACK lasts exactly one cycle, the cycle the pulse is high.
- Reset (sync, high):
  - All mb_valid, send_ok, recv_ready cleared to 0; recv_data set to 0.0.
  - Pending and in-flight messages are discarded; reset mid-handshake yields no pulse afterward.
- Send protocol:
  - Core holds send_ready, send_core_idx and send_data stable until it sees send_ok.
  - Accept at edge ending cycle N if send_ready[c]=1, send_ok[c]=0 and mb_valid[c][dst]=0 at cycle N.
  - On accept: mb_data<=send_data, mb_valid<=1, send_ok[c]=1 during cycle N+1 only.
  - A request still present during the send_ok cycle is ignored, so there are no duplicate deposits. Back-to-back sends therefore run at most 1 per 2 cycles per core.
  - If the slot is full, the request stalls with no timeout until the slot drains.
- Receive protocol:
  - Core holds recv_request and recv_core_idx until it sees recv_ready.
  - Grant at edge ending cycle M if recv_request[c]=1, recv_ready[c]=0 and mb_valid[src][c]=1.
  - On grant: recv_data[c]<=mb_data[src][c], mb_valid[src][c]<=0, recv_ready[c]=1 during cycle M+1 only.
  - recv_data holds its last value otherwise.
- Latency:
  - Send accept to earliest possible recv_ready for that message is 2 cycles (slot visible the cycle after deposit).
  - No combinational path from any input to any output.
- Simultaneous events:
  - Each slot has exactly one writer (src) and one reader (dst), so no arbitration is needed.
  - Fill requires an empty slot and drain requires a full slot at cycle start, so fill and drain never hit the same slot in one cycle.
  - A core may send and receive in the same cycle; the two paths are independent.
  - Multiple cores sending to one destination go to distinct slots and all are accepted in parallel.
- Self-send (dst==src) is legal and uses mb[c][c].
- Ordering: one message per slot, so per-pair order is preserved. No ordering is guaranteed across different sources.
- Arithmetic: payload is passed through bit-exact; the switch does no FP operations.

Test Plan:
- Reset then idle 5 cycles -> send_ok=0, recv_ready=0, slot_full=0, recv_data all 0.0.
- Core0 sends {1.0,2.0,...,16.0} to core2 at cycle 1 -> send_ok[0]=1 in cycle 2 only, slot_full bit 2 set. Core2 requests src 0 at cycle 3 -> recv_ready[2]=1 in cycle 4 with identical data, bit 2 cleared.
- Core1 sends 5.0-filled vector to core3, then immediately sends 7.0-filled vector to core3 with core3 not receiving -> first acked, second stalls with send_ok low. After core3 receives (gets 5.0s), the second is accepted and then received as 7.0s.
- Cores 0, 1 and 2 send to core3 in the same cycle -> all three send_ok pulse together. Core3 receives src 2, 0, 1 in sequence -> data matches each sender.
- Core2 recv_request for src1 with empty mailbox for 10 cycles -> recv_ready stays 0. Core1 then sends -> recv_ready[2] pulses 2 cycles after acceptance.
- Core0 sends to core0 and receives in the next cycle -> data returned. Separately, assert reset the cycle after an accept -> send_ok not observed high after reset, slot_full=0.
